// File: rtl/coef_server.sv
// Double-banked coefficient store: the filter reads the active bank while a new bank
// loads into the shadow. Optional load checksum enabled by macro COEF_CHECKSUM_EN.
`timescale 1ns/1ps
module coef_server #(
  parameter int NCOEF = 65,
  parameter int DW    = 18,
  parameter int AW    = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] coefaddress,
  output logic [DW-1:0] coefdata,
  input  logic          loadstart,
  input  logic [DW-1:0] loaddata,
  input  logic          loadvalid,
  output logic          loadready,
  input  logic          coefhold,
  output logic          loaddone,
  output logic          loaderr,
  output logic          activebank
);

  localparam int            CW      = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NCOEF - 1);
  localparam logic [AW:0]   NCOEF_A = (AW + 1)'(NCOEF);

`ifdef COEF_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, PENDING} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;
`endif

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      valid_q;
  logic            activebank_q;
  logic            loadready_q;
  logic            loaddone_q;
  logic [DW-1:0]   coefdata_q;
  logic [DW-1:0]   mem_q [2][NCOEF];
  logic            shadow_sel;
  logic            wr_en;
`ifdef COEF_CHECKSUM_EN
  logic [DW-1:0]   sum_q;
  logic            loaderr_q;
`endif

  // The swap lands one edge after loaddone rises, so during that cycle the bank
  // becoming shadow is still the one flagged active.
  assign shadow_sel = loaddone_q ? activebank_q : ~activebank_q;
  assign wr_en      = (state_q == LOAD) && loadvalid && !loadstart;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_q      <= 2'b00;
      activebank_q <= 1'b0;
      loadready_q  <= 1'b0;
      loaddone_q   <= 1'b0;
`ifdef COEF_CHECKSUM_EN
      sum_q        <= '0;
      loaderr_q    <= 1'b0;
`endif
    end else begin
      loaddone_q <= 1'b0;
      if (loaddone_q) begin
        activebank_q           <= ~activebank_q;
        valid_q[~activebank_q] <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (loadstart) begin
            state_q             <= LOAD;
            cnt_q               <= '0;
            loadready_q         <= 1'b1;
            valid_q[shadow_sel] <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            sum_q               <= '0;
            loaderr_q           <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (loadstart) begin
            cnt_q <= '0;
`ifdef COEF_CHECKSUM_EN
            sum_q <= '0;
`endif
          end else if (loadvalid) begin
`ifdef COEF_CHECKSUM_EN
            sum_q <= sum_q + loaddata;
`endif
            if (cnt_q == LAST) begin
`ifdef COEF_CHECKSUM_EN
              state_q     <= CHECK;
`else
              state_q     <= PENDING;
              loadready_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`ifdef COEF_CHECKSUM_EN
        CHECK: begin
          if (loadvalid) begin
            loadready_q <= 1'b0;
            if (loaddata == sum_q) begin
              state_q <= PENDING;
            end else begin
              loaderr_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
`endif
        PENDING: begin
          if (!coefhold) begin
            loaddone_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          loadready_q <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient storage is deliberately left unreset; valid bits gate reads.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[~activebank_q][cnt_q] <= loaddata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coefdata_q <= '0;
    end else if (({1'b0, coefaddress} < NCOEF_A) && valid_q[activebank_q]) begin
      coefdata_q <= mem_q[activebank_q][coefaddress];
    end else begin
      coefdata_q <= '0;
    end
  end

  assign coefdata   = coefdata_q;
  assign loadready  = loadready_q;
  assign loaddone   = loaddone_q;
  assign activebank = activebank_q;
`ifdef COEF_CHECKSUM_EN
  assign loaderr    = loaderr_q;
`else
  assign loaderr    = 1'b0;
`endif

endmodule

// File: tb/tb_coef_server.sv
// Directed bench for coef_server: table-driven reads plus hand-written load/hold/
// restart/reset sequences; checksum cases are built when COEF_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_coef_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  coefaddress = '0;
  logic [17:0] coefdata;
  logic        loadstart = 1'b0;
  logic [17:0] loaddata = '0;
  logic        loadvalid = 1'b0;
  logic        loadready;
  logic        coefhold = 1'b0;
  logic        loaddone;
  logic        loaderr;
  logic        activebank;

  coef_server dut (
    .clock      (clk),
    .reset      (rst),
    .coefaddress(coefaddress),
    .coefdata   (coefdata),
    .loadstart  (loadstart),
    .loaddata   (loaddata),
    .loadvalid  (loadvalid),
    .loadready  (loadready),
    .coefhold   (coefhold),
    .loaddone   (loaddone),
    .loaderr    (loaderr),
    .activebank (activebank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [17:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [17:0] words [65];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fill_ramp(input logic [17:0] base);
    for (int i = 0; i < 65; i++) words[i] = base + 18'(i);
  endtask

  task automatic fill_const(input logic [17:0] v);
    for (int i = 0; i < 65; i++) words[i] = v;
  endtask

  task automatic check_read(input string nm, input logic [6:0] a, input logic [17:0] exp);
    coefaddress = a;
    @(posedge clk); #1;
    chk(nm, 32'(coefdata), 32'(exp));
  endtask

  task automatic run_table(input string nm, input int n);
    for (int i = 0; i < n; i++) check_read(nm, tbl[i].addr, tbl[i].exp);
  endtask

  task automatic start_load();
    @(posedge clk); #1 loadstart = 1'b1;
    @(posedge clk); #1 loadstart = 1'b0;
    chk("loadready_in_load", 32'(loadready), 32'd1);
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      loaddata  = words[i];
      loadvalid = 1'b1;
      @(posedge clk); #1;
    end
    loadvalid = 1'b0;
  endtask

  task automatic send_check(input logic [17:0] v);
    loaddata  = v;
    loadvalid = 1'b1;
    @(posedge clk); #1;
    loadvalid = 1'b0;
  endtask

  function automatic logic [17:0] word_sum();
    logic [17:0] s = '0;
    for (int i = 0; i < 65; i++) s = s + words[i];
    return s;
  endfunction

  task automatic full_load();
    start_load();
    send_words(65);
`ifdef COEF_CHECKSUM_EN
    send_check(word_sum());
`endif
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!loaddone && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(loaddone), 32'd1);
  endtask

  initial begin
    int pulses;
    int bad;

    // Reset state and reads of an empty bank
    #12;
    chk("rst_coefdata", 32'(coefdata), 32'd0);
    chk("rst_loadready", 32'(loadready), 32'd0);
    chk("rst_loaddone", 32'(loaddone), 32'd0);
    chk("rst_loaderr", 32'(loaderr), 32'd0);
    chk("rst_activebank", 32'(activebank), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tbl[0] = '{7'd0, 18'd0};
    tbl[1] = '{7'd64, 18'd0};
    tbl[2] = '{7'd100, 18'd0};
    run_table("empty_read", 3);
    chk("empty_activebank", 32'(activebank), 32'd0);

    // Load 1..65, swap immediately
    fill_ramp(18'd1);
    full_load();
    chk("pending_loadready", 32'(loadready), 32'd0);
    wait_done("load1_done");
    coefaddress = 7'd10;
    @(posedge clk); #1;
    chk("swapcycle_oldbank", 32'(coefdata), 32'd0);
    chk("load1_activebank", 32'(activebank), 32'd1);
    chk("loaddone_one_cycle", 32'(loaddone), 32'd0);
    tbl[0] = '{7'd10, 18'd11};
    tbl[1] = '{7'd64, 18'd65};
    tbl[2] = '{7'd65, 18'd0};
    tbl[3] = '{7'd0, 18'd1};
    tbl[4] = '{7'd127, 18'd0};
    run_table("load1_read", 5);

    // Load 100..164 under coefhold; loadstart while pending must be ignored
    fill_ramp(18'd100);
    coefhold = 1'b1;
    full_load();
    coefaddress = 7'd10;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      loadstart = (k == 5);
      @(posedge clk); #1;
      if (loaddone) pulses++;
    end
    loadstart = 1'b0;
    chk("hold_no_loaddone", 32'(pulses), 32'd0);
    chk("hold_old_data", 32'(coefdata), 32'd11);
    chk("hold_activebank", 32'(activebank), 32'd1);
    coefhold = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_done", 32'(loaddone), 32'd1);
    @(posedge clk); #1;
    chk("release_cycle_old", 32'(coefdata), 32'd11);
    chk("hold_activebank_new", 32'(activebank), 32'd0);
    tbl[0] = '{7'd10, 18'd110};
    tbl[1] = '{7'd0, 18'd100};
    tbl[2] = '{7'd64, 18'd164};
    run_table("hold_new_read", 3);

    // Restart after 30 words, then 65 words of all-ones
    start_load();
    fill_const(18'd7);
    send_words(30);
    fill_const(18'h3FFFF);
    full_load();
    wait_done("restart_done");
    @(posedge clk); #1;
    chk("restart_activebank", 32'(activebank), 32'd1);
    bad = 0;
    for (int a = 0; a < 65; a++) begin
      coefaddress = 7'(a);
      @(posedge clk); #1;
      if (coefdata !== 18'h3FFFF) bad++;
    end
    chk("restart_all_ones", 32'(bad), 32'd0);

    // Asynchronous reset at word 40
    coefaddress = 7'd0;
    fill_ramp(18'd1);
    start_load();
    send_words(40);
    chk("pre_reset_data", 32'(coefdata), 32'h3FFFF);
    #2 rst = 1'b1;
    #1;
    chk("async_coefdata", 32'(coefdata), 32'd0);
    chk("async_loadready", 32'(loadready), 32'd0);
    chk("async_activebank", 32'(activebank), 32'd0);
    chk("async_loaddone", 32'(loaddone), 32'd0);
    chk("async_loaderr", 32'(loaderr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check_read("post_reset_invalid", 7'd0, 18'd0);
    full_load();
    wait_done("post_reset_done");
    @(posedge clk); #1;
    chk("post_reset_activebank", 32'(activebank), 32'd1);
    tbl[0] = '{7'd10, 18'd11};
    tbl[1] = '{7'd64, 18'd65};
    run_table("post_reset_read", 2);

`ifdef COEF_CHECKSUM_EN
    // Good checksum swaps, bad checksum flags loaderr and keeps old bank
    fill_ramp(18'd1);
    start_load();
    send_words(65);
    chk("cks_in_check_ready", 32'(loadready), 32'd1);
    send_check(18'd2145);
    wait_done("cks_good_done");
    @(posedge clk); #1;
    chk("cks_good_activebank", 32'(activebank), 32'd0);
    check_read("cks_good_read", 7'd10, 18'd11);
    fill_ramp(18'd500);
    start_load();
    send_words(65);
    send_check(word_sum() - 18'd1);
    chk("cks_bad_loaderr", 32'(loaderr), 32'd1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (loaddone) pulses++;
    end
    chk("cks_bad_no_done", 32'(pulses), 32'd0);
    chk("cks_bad_activebank", 32'(activebank), 32'd0);
    check_read("cks_bad_old_data", 7'd10, 18'd11);
`else
    chk("loaderr_tied", 32'(loaderr), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/coef_server.md
COEF_SERVER -- requirements
Module: coef_server

Interface
REQ-001 SHALL have parameter NCOEF, default 65, number of coefficients per bank.
REQ-002 SHALL have parameter DW, default 18, coefficient width in bits.
REQ-003 SHALL have parameter AW, default 7, read address width.
REQ-004 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port coefaddress  input  AW  read address from the filter.
REQ-007 SHALL have port coefdata  output  DW  registered read data.
REQ-008 SHALL have port loadstart  input  1  one-cycle pulse that begins a bank load.
REQ-009 SHALL have port loaddata  input  DW  load word.
REQ-010 SHALL have port loadvalid  input  1  loaddata valid this cycle.
REQ-011 SHALL have port loadready  output  1  block accepts a load word this cycle.
REQ-012 SHALL have port coefhold  input  1  filter mid-convolution; defers bank swap.
REQ-013 SHALL have port loaddone  output  1  one-cycle pulse when a new bank goes active.
REQ-014 SHALL have port loaderr  output  1  sticky load error flag.
REQ-015 SHALL have port activebank  output  1  index of the bank serving reads.

Function
REQ-016 SHALL hold two banks of NCOEF x DW words, active and shadow, plus one valid bit per bank.
REQ-017 SHALL register coefdata one cycle after coefaddress: active[coefaddress] if coefaddress < NCOEF and the active bank is valid, else 0.
REQ-018 SHALL run FSM IDLE -> LOAD -> (CHECK) -> PENDING -> IDLE.
REQ-019 IDLE: loadready=0; loadstart -> LOAD, word counter cleared to 0, loaderr cleared.
REQ-020 LOAD: loadready=1; each cycle with loadvalid=1 writes loaddata to shadow[counter] and increments counter.
REQ-021 LOAD: the write at counter = NCOEF-1 SHALL move to CHECK (macro defined) or PENDING (macro undefined).
REQ-022 loadstart during LOAD SHALL restart the load: counter to 0; words already written are overwritten by the restart.
REQ-023 loadstart in CHECK or PENDING SHALL be ignored.
REQ-024 PENDING: loadready=0; on the first cycle with coefhold=0, swap banks, set new active valid bit, pulse loaddone for 1 cycle, go IDLE.
REQ-025 The swap SHALL take effect for the read registered in the cycle after loaddone; a read in the loaddone cycle still returns the old bank.
REQ-026 Reads SHALL never be stalled by loading; load writes only touch the shadow bank.
REQ-027 The shadow valid bit SHALL be cleared on entry to LOAD.

Reset
REQ-028 reset SHALL asynchronously force: state IDLE, counter 0, coefdata 0, loadready 0, loaddone 0, loaderr 0, activebank 0, both bank valid bits 0.
REQ-029 Bank word storage SHALL NOT be reset; invalid banks read as 0 per REQ-017.
REQ-030 Reset asserted mid-load SHALL abandon the load with no swap.

Configuration
REQ-031 Macro COEF_CHECKSUM_EN SHALL be used.
REQ-032 With COEF_CHECKSUM_EN defined: LOAD accumulates a DW-bit modulo-2^DW sum of all NCOEF words.
REQ-033 With COEF_CHECKSUM_EN defined: CHECK keeps loadready=1 and accepts one extra word.
REQ-034 With COEF_CHECKSUM_EN defined: if the extra word equals the sum, go to PENDING.
REQ-035 With COEF_CHECKSUM_EN defined: on a mismatch, set loaderr, keep the shadow invalid, do not swap, and return to IDLE.
REQ-036 Without COEF_CHECKSUM_EN: no CHECK state, no sum logic, and loaderr is tied to 0.

Verification
REQ-037 Reset, then read addresses 0, 64, 100 -> coefdata = 0 each, one cycle later; activebank = 0.
REQ-038 Load words 1..65 with coefhold=0 -> loaddone pulse and activebank = 1; address 10 -> 11; address 64 -> 65; address 65 -> 0.
REQ-039 Complete a load with coefhold=1 held 20 cycles -> no loaddone and old data served; drop coefhold -> loaddone next cycle, then new data.
REQ-040 Send loadstart after 30 words, then load 65 words of 0x3FFFF -> every address 0..64 reads 0x3FFFF.
REQ-041 Macro defined; load 1..65, then send checksum 2145 -> swap; repeat with checksum 2144 -> loaderr = 1, no swap, old data served.
REQ-042 Assert reset at word 40 of a load -> all outputs 0 asynchronously; a following full load works normally.
